// File: rtl/if_sdp_fifo_b_pkg.sv
// if_sdp_fifo_b_pkg
//   Shared sizing helpers for the block-RAM FIFO.
//   rl_of : RAM read latency for a given output-register setting.
//   sd_of : prefetch skid depth (RL+1) that covers a full round trip.
//   cnt_w : RAM occupancy counter width (must hold 2**AW itself).
//   lvl_w : total level width (RAM + in-flight + skid).
package if_sdp_fifo_b_pkg;

  // Skid/in-flight counts never exceed RL+1 <= 3; 4 bits leaves headroom
  // for the intermediate sum in the issue check.
  localparam int SCW = 4;

  function automatic int rl_of(input bit oreg);
    return oreg ? 2 : 1;
  endfunction

  function automatic int sd_of(input bit oreg);
    return rl_of(oreg) + 1;
  endfunction

  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int lvl_w(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/if_sdp_ram_b.sv
// if_sdp_ram_b
//   Simple dual-port block RAM, one clock for both ports.
//   A port : a_ce/a_we/a_ad/a_wd write.
//   B port : b_ce/b_ad read, b_rd data after 1 cycle (OREG=0) or 2 (OREG=1).
//   No reset on storage or read registers.
module if_sdp_ram_b #(
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter bit OREG = 1'b1
) (
  input  logic          Ck,
  input  logic          a_ce,
  input  logic          a_we,
  input  logic [AW-1:0] a_ad,
  input  logic [DW-1:0] a_wd,
  input  logic          b_ce,
  input  logic [AW-1:0] b_ad,
  output logic [DW-1:0] b_rd
);

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_q;

  always_ff @(posedge Ck) begin
    if (a_ce && a_we) mem[a_ad] <= a_wd;
  end

  always_ff @(posedge Ck) begin
    if (b_ce) rd_q <= mem[b_ad];
  end

  if (OREG) begin : g_oreg
    logic [DW-1:0] rd_q2;
    always_ff @(posedge Ck) begin
      if (b_ce) rd_q2 <= rd_q;
    end
    assign b_rd = rd_q2;
  end else begin : g_noreg
    assign b_rd = rd_q;
  end

endmodule

// File: rtl/if_sdp_fifo_b.sv
// if_sdp_fifo_b
//   Single-clock elastic FIFO over if_sdp_ram_b with a first-word-fall-through
//   valid/ready read side. A small skid buffer (RL+1 entries) is prefetched
//   from the RAM so the output sustains one word per cycle.
//   Ck, Rst        : clock, synchronous active-high reset
//   Wr_En, Wr_D    : write request/data; ignored while Full
//   Full, Ovf      : RAM full; registered pulse for a write seen while Full
//   Rd_Vld/Rdy/D   : head-of-queue stream, Rd_D held while stalled
//   Empty, Level   : total words held (RAM + in flight + skid)
module if_sdp_fifo_b
  import if_sdp_fifo_b_pkg::*;
#(
  parameter int    AW = 4,
  parameter int    DW = 8,
  parameter string OR = "TRUE"
) (
  input  logic          Ck,
  input  logic          Rst,
  input  logic          Wr_En,
  input  logic [DW-1:0] Wr_D,
  output logic          Full,
  output logic          Ovf,
  output logic          Rd_Vld,
  input  logic          Rd_Rdy,
  output logic [DW-1:0] Rd_D,
  output logic          Empty,
  output logic [AW+1:0] Level
);

  localparam bit OREG = (OR == "TRUE");
  localparam int RL   = rl_of(OREG);
  localparam int SD   = sd_of(OREG);
  localparam int CW   = cnt_w(AW);
  localparam int LW   = lvl_w(AW);
  localparam int SPW  = $clog2(SD);

  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  ram_cnt;     // written but not yet issued
  logic [RL-1:0]  vld_pipe;    // one bit per issued read, exits with b_rd
  logic [SCW-1:0] infl;
  logic [SCW-1:0] skid_cnt;
  logic [DW-1:0]  skid [SD];
  logic [SPW-1:0] hd, tl;
  logic [DW-1:0]  b_rd;
  logic           ovf_q;
  logic           wr_acc, rd_iss, pop, push, b_ce;

  function automatic logic [SPW-1:0] nxt(input logic [SPW-1:0] p);
    return (p == SPW'(SD-1)) ? '0 : p + 1'b1;
  endfunction

  assign b_ce   = 1'b1;
  assign Full   = (ram_cnt == CW'(1 << AW));
  assign wr_acc = Wr_En & ~Full;
  assign Rd_Vld = (skid_cnt != '0);
  assign pop    = Rd_Vld & Rd_Rdy;
  assign push   = vld_pipe[RL-1];

  always_comb begin
    infl = '0;
    for (int i = 0; i < RL; i++) infl = infl + SCW'(vld_pipe[i]);
  end

  // Issue only if the word will have a skid slot when it lands: words already
  // in the skid plus those in flight, net of this cycle's pop, stay <= RL.
  // ram_cnt only counts writes completed on an earlier edge, so the read never
  // targets the address being written this cycle.
  assign rd_iss = (ram_cnt != '0) && ((skid_cnt + infl - SCW'(pop)) <= SCW'(RL));

  if_sdp_ram_b #(.AW(AW), .DW(DW), .OREG(OREG)) u_ram (
    .Ck   (Ck),
    .a_ce (wr_acc),
    .a_we (wr_acc),
    .a_ad (wptr),
    .a_wd (Wr_D),
    .b_ce (b_ce),
    .b_ad (rptr),
    .b_rd (b_rd)
  );

  always_ff @(posedge Ck) begin
    if (Rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      vld_pipe <= '0;
      skid_cnt <= '0;
      hd       <= '0;
      tl       <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < SD; i++) skid[i] <= '0;
    end else begin
      wptr     <= wptr + AW'(wr_acc);
      rptr     <= rptr + AW'(rd_iss);
      ram_cnt  <= ram_cnt + CW'(wr_acc) - CW'(rd_iss);
      vld_pipe <= RL'({vld_pipe, rd_iss});
      ovf_q    <= Wr_En & Full;
      skid_cnt <= skid_cnt + SCW'(push) - SCW'(pop);
      if (push) begin
        skid[tl] <= b_rd;
        tl       <= nxt(tl);
      end
      if (pop) hd <= nxt(hd);
    end
  end

  assign Ovf   = ovf_q;
  assign Rd_D  = skid[hd];
  assign Level = LW'(ram_cnt) + LW'(infl) + LW'(skid_cnt);
  assign Empty = (Level == '0);

endmodule
